fft_reorder_buf: RTL and testbench
==================================

# fft_reorder_buf

Parametrised streaming bit-reversal reorder buffer for the radix-2 FFT pipeline. It accepts one complex sample per cycle in FFT output order, index k, and stores it at natural address bitrev(k). Completed frames leave as a natural-order stream with valid/ready handshakes. Ping-pong double buffering sustains continuous throughput and replaces the earlier fixed 32-point parallel-output sorter.

## Interface
Parameters:
- DATA_W, 16: signed width of each real/imag component.
- LOG2N, 5: log2 of FFT size; N = 2**LOG2N, legal range 2..10.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of counters and bank state; data arrays are not cleared.
- in_valid  in  1  input sample present.
- in_ready  out  1  buffer can accept a sample.
- in_r, in_i  in  DATA_W each  signed input sample.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts the sample.
- out_r, out_i  out  DATA_W each  signed output sample, natural order.
- out_idx  out  LOG2N  natural frequency index of the current output.
- out_last  out  1  high with out_idx == N-1.
- frame_cnt  out  16  completed output frames; present only with FFT_REORDER_FRAME_CNT_EN.

## Operation
- Storage: two banks, each N x 2·DATA_W, held in flops. Per-bank full flag. Write-bank pointer wb, read-bank pointer rb, write counter wr_cnt, read counter rd_cnt (LOG2N bits each).
- Each bank cycles through two states: FILLING (full=0) and DRAINING (full=1).
- in_ready = !full[wb]. An input is accepted when in_valid && in_ready. Accepting writes bank[wb][bitrev(wr_cnt)] and increments wr_cnt. On accepting wr_cnt == N-1: set full[wb], toggle wb, wrap wr_cnt to 0.
- out_valid = full[rb]. out_r/out_i = bank[rb][rd_cnt], out_idx = rd_cnt. An output transfers when out_valid && out_ready; each transfer increments rd_cnt. On transferring rd_cnt == N-1: clear full[rb], toggle rb, wrap rd_cnt to 0.
- Outputs stay stable while out_valid && !out_ready.
- Simultaneous set of one bank's full flag and clear of the other's in the same cycle is legal, and both take effect.
- A bank cleared at cycle t is writable at t+1, because in_ready is derived from registered flags.
- flush has priority over any handshake in the same cycle. It forces wr_cnt=rd_cnt=0, wb=rb=0, full=0, and frame_cnt=0. The transfer in the flush cycle is discarded.
- Width rule: data is stored and passed unmodified, with no rounding or saturation.
- bitrev(k) reverses the LOG2N bits of k.

## Timing
- Reset values: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_r=out_i=0 (arrays reset to 0), frame_cnt=0. All counters, pointers and flags are 0.
- Latency: the first output of a frame is valid the cycle after its N-th input is accepted.
- Throughput: 1 sample/cycle indefinitely when out_ready=1.
- Backpressure: with out_ready held 0, at most 2N samples are accepted, then in_ready=0.
- Reset asserted mid-frame: everything clears immediately, and the partial frame is lost.

## Configuration
- FFT_REORDER_FRAME_CNT_EN
  - Defined: port frame_cnt exists. It increments on each transfer with out_last=1 and wraps from 0xFFFF to 0. It clears on reset and on flush.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package fft_pkg holds:
  - the default DATA_W;
  - the bitrev function, parameterised on LOG2N;
  - a complex-sample struct typedef {re, im}.
- One sub-module, fft_reorder_bank: a single N-entry bank with write port, async read port and full flag. The top instantiates two of these plus the pointer and counter control.

## Test plan
All scenarios use N=32, DATA_W=16.
- Single frame: feed in_r=k, in_i=-k for k=0..31 with out_ready=1. Required: out_valid rises the cycle after the 32nd accept, and the outputs are out_idx 0..31 with out_r = 0,16,8,24,4,…,31 (= bitrev(idx)), out_i = -out_r, and out_last only at idx 31.
- Back-to-back: 4 frames streamed continuously with out_ready=1. Required: in_ready never drops, and 128 outputs emerge contiguously with correct values per frame.
- Backpressure: out_ready=0, in_valid=1 continuously. Required: exactly 64 accepts, then in_ready=0. Raising out_ready releases frame 0 first, and in_ready returns one cycle after out_last.
- Output stall: toggle out_ready randomly. Required: no sample is dropped or duplicated, and out_* stay stable during the stall.
- Flush mid-frame: after 10 inputs, pulse flush together with in_valid. Required: the next frame starts at wr_cnt=0, out_valid=0 until 32 new accepts, and frame_cnt=0.
- Reset mid-drain: assert rst at out_idx=12. Required: out_valid=0, in_ready=1 and out_r=0 immediately. With the macro defined, frame_cnt counts 1 after the next full frame.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT pipeline: default sample width, bank states,
// complex-sample struct and the LOG2N-bit bit-reversal helper.
package fft_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LOG2N_MAX  = 10;

  typedef enum logic {
    FILLING  = 1'b0,
    DRAINING = 1'b1
  } bank_state_t;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] re;
    logic signed [DATA_W_DEF-1:0] im;
  } cplx_t;

  // Reverses the low log2n bits of k; bits at and above log2n return as zero.
  function automatic logic [LOG2N_MAX-1:0] bitrev(input logic [LOG2N_MAX-1:0] k,
                                                  input int log2n);
    logic [LOG2N_MAX-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N_MAX; b++) begin
      if (b < log2n) r[b] = k[log2n-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N-entry sample bank of the reorder buffer: synchronous write port,
// asynchronous read port and a FILLING/DRAINING state exposed as the full flag.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2N  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [LOG2N-1:0]    wr_addr,
  input  logic [2*DATA_W-1:0] wr_data,
  input  logic                set_full,
  input  logic                clr_full,
  input  logic [LOG2N-1:0]    rd_addr,
  output logic [2*DATA_W-1:0] rd_data,
  output logic                full
);

  localparam int N = 1 << LOG2N;

  logic [2*DATA_W-1:0] mem [N];
  bank_state_t         state_q, state_d;

  // NOTE: the array is reset so the first read after reset returns zero;
  // flush deliberately leaves the contents alone and only retires the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < N; a++) mem[a] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILLING;
    else      state_q <= state_d;
  end

  // NOTE: state_d takes its hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FILLING;
    end else begin
      case (state_q)
        FILLING:  if (set_full) state_d = DRAINING;
        DRAINING: if (clr_full) state_d = FILLING;
      endcase
    end
  end

  assign full    = (state_q == DRAINING);
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong bit-reversal reorder buffer: bit-reversed-order samples in, natural
// order out. Optional frame counter port enabled by FFT_REORDER_FRAME_CNT_EN.
module fft_reorder_buf
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2N  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_r,
  output logic signed [DATA_W-1:0] out_i,
  output logic [LOG2N-1:0]         out_idx,
  output logic                     out_last
`ifdef FFT_REORDER_FRAME_CNT_EN
  ,
  output logic [15:0]              frame_cnt
`endif
);

  localparam logic [LOG2N-1:0] LAST = '1;

  logic               wb, rb;
  logic [LOG2N-1:0]   wr_cnt, rd_cnt;
  logic [LOG2N-1:0]   wr_addr;
  logic [1:0]         full;
  logic [2*DATA_W-1:0] rd_data [2];
  logic               acc, xfer, wr_wrap, rd_wrap;

  assign in_ready  = !full[wb];
  assign out_valid = full[rb];
  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign wr_wrap   = acc && (wr_cnt == LAST);
  assign rd_wrap   = xfer && (rd_cnt == LAST);
  assign wr_addr   = LOG2N'(bitrev(LOG2N_MAX'(wr_cnt), LOG2N));

  assign {out_r, out_i} = rd_data[rb];
  assign out_idx        = rd_cnt;
  assign out_last       = out_valid && (rd_cnt == LAST);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_reorder_bank #(
      .DATA_W (DATA_W),
      .LOG2N  (LOG2N)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .wr_en    (acc && !flush && (wb == 1'(g))),
      .wr_addr  (wr_addr),
      .wr_data  ({in_r, in_i}),
      .set_full (wr_wrap && !flush && (wb == 1'(g))),
      .clr_full (rd_wrap && !flush && (rb == 1'(g))),
      .rd_addr  (rd_cnt),
      .rd_data  (rd_data[g]),
      .full     (full[g])
    );
  end

  // Counters wrap naturally at N; pointers flip on the last sample of a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (flush) begin
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (acc)     wr_cnt <= wr_cnt + 1'b1;
      if (wr_wrap) wb     <= ~wb;
      if (xfer)    rd_cnt <= rd_cnt + 1'b1;
      if (rd_wrap) rb     <= ~rb;
    end
  end

`ifdef FFT_REORDER_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  frame_cnt <= '0;
    else if (flush)            frame_cnt <= '0;
    else if (xfer && out_last) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Directed bench for fft_reorder_buf at N=32, DATA_W=16: reset, single frame,
// streaming, backpressure, random stalls, flush and mid-drain reset.
module tb_fft_reorder_buf;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_r = '0;
  logic [15:0] in_i = '0;
  logic        in_ready, out_valid, out_last;
  logic [15:0] out_r, out_i;
  logic [4:0]  out_idx;
`ifdef FFT_REORDER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fft_reorder_buf #(.DATA_W(16), .LOG2N(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef FFT_REORDER_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [4:0] rev5(input logic [4:0] k);
    return {k[0], k[1], k[2], k[3], k[4]};
  endfunction

  // Input value of stream sample s is s itself, so natural output n carries
  // the frame base plus bitrev of its index.
  function automatic logic [15:0] exp_r(input int n);
    return 16'((n / N) * N + int'(rev5(5'(n % N))));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic run_stream(input int n_in, input bit rnd, input int budget);
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    bit          acc, xfer;
    logic [15:0] s_r, s_i;
    logic [4:0]  s_idx;
    s_r = '0; s_i = '0; s_idx = '0;
    while (got < n_in && cyc < budget) begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", {out_r, out_i}, {s_r, s_i});
        check("stall_idx", 32'(out_idx), 32'(s_idx));
      end
      if (got == 0) check("latency", 32'(out_valid), 32'(sent >= N));
      if (!rnd && sent < n_in) check("in_ready_cont", 32'(in_ready), 32'd1);
      if (!rnd && got > 0) check("out_contig", 32'(out_valid), 32'd1);
      in_valid  = (sent < n_in);
      in_r      = 16'(sent);
      in_i      = 16'(-sent);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        check("idx", 32'(out_idx), 32'(got % N));
        check("re", 32'(out_r), 32'(exp_r(got)));
        check("im", 32'(out_i), 32'(16'(-exp_r(got))));
        check("last", 32'(out_last), 32'((got % N) == N - 1));
      end
      stalled = out_valid && !out_ready;
      s_r = out_r; s_i = out_i; s_idx = out_idx;
      step();
      if (acc)  sent++;
      if (xfer) got++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_done", 32'(got), 32'(n_in));
  endtask

  initial begin
    int n_acc;
    int guard;

    // Reset state, sampled while reset is still asserted.
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", {out_r, out_i}, 32'd0);
`ifdef FFT_REORDER_FRAME_CNT_EN
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    #10 rst = 1'b1;
    step();

    // Single frame: outputs 0,16,8,24,4,... with im = -re.
    run_stream(32, 1'b0, 100);
`ifdef FFT_REORDER_FRAME_CNT_EN
    check("frame_cnt_one", 32'(frame_cnt), 32'd1);
`endif

    // Four frames back to back.
    flush_pulse();
    run_stream(128, 1'b0, 300);

    // Backpressure: two banks fill, then input stalls.
    flush_pulse();
    n_acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      in_r = 16'(n_acc);
      in_i = 16'(-n_acc);
      if (in_ready) n_acc++;
      step();
    end
    in_valid = 1'b0;
    check("bp_accepts", 32'(n_acc), 32'd64);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_first_re", 32'(out_r), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_idx", 32'(out_idx), 32'(i % N));
      check("bp_re", 32'(out_r), 32'(exp_r(i)));
      if (i == 31) begin
        check("bp_last", 32'(out_last), 32'd1);
        check("bp_hold", 32'(in_ready), 32'd0);
      end
      step();
      if (i == 31) check("bp_release", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;
    check("bp_empty", 32'(out_valid), 32'd0);

    // Random output stalls.
    flush_pulse();
    run_stream(96, 1'b1, 2000);

    // Flush after 10 inputs; the flush-cycle sample is discarded.
    flush_pulse();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_r = 16'(500 + i);
      in_i = 16'(i);
      step();
    end
    flush = 1'b1;
    in_r  = 16'd777;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_out_idx", 32'(out_idx), 32'd0);
`ifdef FFT_REORDER_FRAME_CNT_EN
    check("fl_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    run_stream(32, 1'b0, 100);

    // Reset in the middle of draining a frame.
    flush_pulse();
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_r = 16'(100 + i);
      in_i = 16'(i);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (out_idx != 5'd12 && guard < 40) begin
      step();
      guard++;
    end
    check("rd_reach12", 32'(out_idx), 32'd12);
    rst = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_out_r", 32'(out_r), 32'd0);
    check("mr_out_idx", 32'(out_idx), 32'd0);
    #2 rst = 1'b1;
    step();
    run_stream(32, 1'b0, 100);
`ifdef FFT_REORDER_FRAME_CNT_EN
    check("mr_frame_cnt", 32'(frame_cnt), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
